// File: rtl/datapath_pkg.sv
// Shared encodings for the single-bus datapath: bus driver selects, ALU
// operations and the run/memory state machine states.
package datapath_pkg;

  typedef enum logic [3:0] {
    SRC_REG    = 4'd0,
    SRC_PC     = 4'd1,
    SRC_MDR    = 4'd2,
    SRC_INPORT = 4'd3,
    SRC_HI     = 4'd4,
    SRC_LO     = 4'd5,
    SRC_ZLO    = 4'd6,
    SRC_ZHI    = 4'd7,
    SRC_Y      = 4'd8,
    SRC_CONST0 = 4'd9
  } bus_src_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_NOT  = 4'd4,
    ALU_NEG  = 4'd5,
    ALU_SHL  = 4'd6,
    ALU_SHR  = 4'd7,
    ALU_SHRA = 4'd8,
    ALU_ROL  = 4'd9,
    ALU_ROR  = 4'd10,
    ALU_MUL  = 4'd11
  } alu_op_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } run_state_t;

  typedef enum logic [1:0] {
    MEM_IDLE    = 2'd0,
    MEM_RD_WAIT = 2'd1,
    MEM_WR_WAIT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A is the Y register, B is the bus. The double-width
// result feeds Z = {ZHI, ZLO}.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]          op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [2*DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]     sh;
  logic [DATA_W-1:0]   lo;
  logic                sext;
  logic                mul_sel;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] rot;

  assign sh = b[SH_W-1:0];

  always_comb begin
    lo      = '0;
    sext    = 1'b0;
    mul_sel = 1'b0;
    rot     = '0;
    // Truncating the product of sign-extended operands gives the signed product.
    prod    = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
    case (alu_op_t'(op))
      ALU_ADD:  begin lo = a + b;  sext = 1'b1; end
      ALU_SUB:  begin lo = a - b;  sext = 1'b1; end
      ALU_AND:  lo = a & b;
      ALU_OR:   lo = a | b;
      ALU_NOT:  lo = ~b;
      ALU_NEG:  begin lo = '0 - b; sext = 1'b1; end
      ALU_SHL:  lo = a << sh;
      ALU_SHR:  lo = a >> sh;
      ALU_SHRA: lo = $signed(a) >>> sh;
      ALU_ROL:  begin rot = {a, a} << sh; lo = rot[2*DATA_W-1:DATA_W]; end
      ALU_ROR:  begin rot = {a, a} >> sh; lo = rot[DATA_W-1:0]; end
      ALU_MUL:  mul_sel = 1'b1;
      default:  lo = '0;
    endcase
    result = mul_sel ? prod : {{DATA_W{sext & lo[DATA_W-1]}}, lo};
  end

endmodule

// File: rtl/bus_datapath.sv
// Single-bus CPU datapath: register file, special registers, bus mux, ALU,
// run/halt control and a handshaked memory port behind MAR/MDR.
module bus_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stop,
  output logic              run,
  input  logic [3:0]        bus_src,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              ba_out,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              reg_in,
  input  logic              pc_in,
  input  logic              ir_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              y_in,
  input  logic              z_in,
  input  logic              hi_in,
  input  logic              lo_in,
  input  logic              outport_in,
  input  logic              inc_pc,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] ir_q,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   pc_reg, ir_reg, mar_reg, mdr_reg;
  logic [DATA_W-1:0]   hi_reg, lo_reg, y_reg, inport_reg, out_reg;
  logic [2*DATA_W-1:0] z_reg;
  logic [2*DATA_W-1:0] alu_result;
  logic [DATA_W-1:0]   bus;

  run_state_t run_reg, run_next;
  mem_state_t mem_reg, mem_next;
  logic       mem_err_reg, mem_err_next;
  logic       active, busy, rd_done;

  assign active = (run_reg == RUN);
  assign busy   = (mem_reg != MEM_IDLE);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    logic [DATA_W-1:0] value_reg;
    always_ff @(posedge clock) begin
      if (!reset) value_reg <= '0;
      else if (active && reg_in && wr_idx == IDX_W'(gi)) value_reg <= bus;
    end
    assign regs[gi] = value_reg;
  end

  always_comb begin
    bus = '0;
    case (bus_src_t'(bus_src))
      SRC_REG:    bus = (ba_out && rd_idx == '0) ? '0 : regs[rd_idx];
      SRC_PC:     bus = pc_reg;
      SRC_MDR:    bus = mdr_reg;
      SRC_INPORT: bus = inport_reg;
      SRC_HI:     bus = hi_reg;
      SRC_LO:     bus = lo_reg;
      SRC_ZLO:    bus = z_reg[DATA_W-1:0];
      SRC_ZHI:    bus = z_reg[2*DATA_W-1:DATA_W];
      SRC_Y:      bus = y_reg;
      default:    bus = '0;
    endcase
  end

  datapath_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (alu_op),
    .a      (y_reg),
    .b      (bus),
    .result (alu_result)
  );

  always_comb begin
    run_next = run_reg;
    if (run_reg == RUN && stop) run_next = HALT;
  end

  // A transaction already in flight completes even after the datapath halts.
  always_comb begin
    mem_next     = mem_reg;
    mem_err_next = mem_err_reg;
    rd_done      = 1'b0;
    case (mem_reg)
      MEM_IDLE: begin
        if (active) begin
          if (mem_read)       mem_next = MEM_RD_WAIT;
          else if (mem_write) mem_next = MEM_WR_WAIT;
          if (mem_read && mem_write) mem_err_next = 1'b1;
        end
      end
      MEM_RD_WAIT: begin
        if (mem_ready) begin
          rd_done  = 1'b1;
          mem_next = MEM_IDLE;
        end
        if (active && (mem_read || mem_write)) mem_err_next = 1'b1;
      end
      MEM_WR_WAIT: begin
        if (mem_ready) mem_next = MEM_IDLE;
        if (active && (mem_read || mem_write)) mem_err_next = 1'b1;
      end
      default: mem_next = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      run_reg     <= RUN;
      mem_reg     <= MEM_IDLE;
      mem_err_reg <= 1'b0;
    end else begin
      run_reg     <= run_next;
      mem_reg     <= mem_next;
      mem_err_reg <= mem_err_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_reg     <= '0;
      ir_reg     <= '0;
      mar_reg    <= '0;
      mdr_reg    <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      y_reg      <= '0;
      z_reg      <= '0;
      inport_reg <= '0;
      out_reg    <= '0;
    end else begin
      inport_reg <= in_data;
      if (rd_done) mdr_reg <= mem_rdata;
      else if (active && mdr_in && !busy) mdr_reg <= bus;
      if (active) begin
        if (pc_in)       pc_reg <= bus;
        else if (inc_pc) pc_reg <= pc_reg + DATA_W'(1);
        if (ir_in)              ir_reg  <= bus;
        if (mar_in && !busy)    mar_reg <= bus;
        if (y_in)               y_reg   <= bus;
        if (z_in)               z_reg   <= alu_result;
        if (hi_in)              hi_reg  <= bus;
        if (lo_in)              lo_reg  <= bus;
        if (outport_in)         out_reg <= bus;
      end
    end
  end

  assign run        = active;
  assign out_data   = out_reg;
  assign ir_q       = ir_reg;
  assign mem_addr   = mar_reg;
  assign mem_wdata  = mdr_reg;
  assign mem_rd_req = (mem_reg == MEM_RD_WAIT);
  assign mem_wr_req = (mem_reg == MEM_WR_WAIT);
  assign mem_busy   = busy;
  assign mem_err    = mem_err_reg;

endmodule
